// File: rtl/ws2812_pkg.sv
// Shared state encoding and default WS2812 timing constants (clk cycles).
package ws2812_pkg;

  localparam int unsigned T0H_DEF  = 8;
  localparam int unsigned T1H_DEF  = 16;
  localparam int unsigned TBIT_DEF = 25;
  localparam int unsigned TRST_DEF = 1000;
  localparam int unsigned CW_DEF   = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLatch = 2'd2
  } state_e;

endpackage

// File: rtl/ws2812_tx.sv
// WS2812 single-wire NRZ transmitter: serialises 24-bit GRB words MSB first,
// chains words back-to-back, and closes each stream with a TRST low latch gap.
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H  = T0H_DEF,
  parameter int unsigned T1H  = T1H_DEF,
  parameter int unsigned TBIT = TBIT_DEF,
  parameter int unsigned TRST = TRST_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_n,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        led_out,
  output logic        busy
);

  localparam logic [CW-1:0] BitLast = CW'(TBIT - 1);
  localparam logic [CW-1:0] RstLast = CW'(TRST - 1);
  localparam logic [CW-1:0] HiOne   = CW'(T1H);
  localparam logic [CW-1:0] HiZero  = CW'(T0H);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   shreg_q, shreg_d;

  logic bit_end, word_end, take;

  assign bit_end  = (state_q == StShift) && (cnt_q == BitLast);
  assign word_end = bit_end && (bit_q == 5'd0);
  assign in_ready = (state_q == StIdle) || word_end;
  assign take     = in_valid && in_ready;
  assign busy     = (state_q != StIdle);
  // Current bit always sits in shreg_q[23]; its high time picks the symbol.
  assign led_out  = (state_q == StShift) && (cnt_q < (shreg_q[23] ? HiOne : HiZero));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (!clear_n) begin
      state_d = StIdle;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (take) begin
            state_d = StShift;
            cnt_d   = '0;
            bit_d   = 5'd23;
            shreg_d = in_data;
          end
        end
        StShift: begin
          if (bit_end) begin
            cnt_d = '0;
            if (bit_q == 5'd0) begin
              if (take) begin
                bit_d   = 5'd23;
                shreg_d = in_data;
              end else begin
                state_d = StLatch;
                shreg_d = '0;
              end
            end else begin
              bit_d   = bit_q - 5'd1;
              shreg_d = {shreg_q[22:0], 1'b0};
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StLatch: begin
          if (cnt_q == RstLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          bit_d   = '0;
          shreg_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: expected bits are queued as words are offered and a line
// monitor decodes each led_out pulse back into a bit and compares in order.
module tb_ws2812_tx;
  import ws2812_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_n = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, led_out, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  int exp_q[$];

  ws2812_tx #(
    .T0H (T0H_DEF),
    .T1H (T1H_DEF),
    .TBIT(TBIT_DEF),
    .TRST(TRST_DEF),
    .CW  (CW_DEF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_n (clear_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .led_out (led_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor: measures each high pulse and the spacing of rising edges.
  initial begin
    int  hi_cnt    = 0;
    int  last_rise = -1000;
    bit  led_prev  = 1'b0;
    int  got;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hi_cnt    = 0;
        last_rise = -1000;
        led_prev  = led_out;
      end else begin
        if (led_out && !led_prev) begin
          if (cyc - last_rise <= int'(TBIT_DEF) + 5)
            check("period", cyc - last_rise, TBIT_DEF);
          last_rise = cyc;
        end
        if (led_out) begin
          hi_cnt++;
        end else if (led_prev) begin
          got = (hi_cnt == int'(T1H_DEF)) ? 1 : (hi_cnt == int'(T0H_DEF)) ? 0 : 100 + hi_cnt;
          if (exp_q.size() == 0) check("extra_bit", 1, 0);
          else check("bit", got, exp_q.pop_front());
          hi_cnt = 0;
        end
        led_prev = led_out;
      end
    end
  end

  // Offer a word from a negedge; returns the cycle of the negedge where the
  // handshake was seen, and leaves the bench at the following negedge.
  task automatic send(input logic [23:0] w, output int acc);
    bit done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 23; i >= 0; i--) exp_q.push_back(int'(w[i]));
    acc = -1;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (in_ready) begin
        acc  = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int a, b, r, n;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_led", led_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Single word 0x800000: 600 shift cycles plus 1000 latch cycles
    send(24'h800000, a);
    check("lat1_led", led_out, 1);
    check("lat1_busy", busy, 1);
    check("lat1_ready", in_ready, 0);
    wait_idle(n);
    check("single_busy_cycles", n, 24 * TBIT_DEF + TRST_DEF);
    check("single_drain", exp_q.size(), 0);
    check("single_ready", in_ready, 1);

    // Back-to-back words, valid held across the boundary
    send(24'hFFFFFF, a);
    send(24'h000000, b);
    check("b2b_accept_gap", b - a, 24 * TBIT_DEF);
    wait_idle(n);
    check("b2b_drain", exp_q.size(), 0);

    // Word offered during LATCH waits for IDLE
    send(24'h123456, a);
    found = 1'b0;
    r = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (in_ready && busy) begin
        r     = cyc;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("latch_entry_seen", found, 1);
    repeat (11) @(negedge clk);
    check("latch_ready", in_ready, 0);
    send(24'h00FF00, b);
    check("latch_accept", b - r, TRST_DEF + 1);
    wait_idle(n);
    check("latch_drain", exp_q.size(), 0);

    // Synchronous clear during bit 12
    send(24'hFFFFFF, a);
    repeat (11 * TBIT_DEF + 3) @(negedge clk);
    check("pre_clear_led", led_out, 1);
    mon_en  = 1'b0;
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    check("clear_led", led_out, 0);
    check("clear_busy", busy, 0);
    check("clear_ready", in_ready, 1);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("clear_no_latch", busy, 0);
    mon_en = 1'b1;

    // Asynchronous reset during a high phase, then a clean word
    send(24'hFFFFFF, a);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_led", led_out, 0);
    check("arst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("arst_ready", in_ready, 1);
    mon_en = 1'b1;
    send(24'hA5A5A5, a);
    check("arst_word_led", led_out, 1);
    wait_idle(n);
    check("arst_busy_cycles", n, 24 * TBIT_DEF + TRST_DEF);
    check("arst_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 SHALL have parameter T0H, default 8, meaning high time of a '0' bit in clk cycles.
REQ-002 SHALL have parameter T1H, default 16, meaning high time of a '1' bit in clk cycles.
REQ-003 SHALL have parameter TBIT, default 25, meaning total bit period in clk cycles (constraint: T0H < T1H < TBIT).
REQ-004 SHALL have parameter TRST, default 1000, meaning low latch/reset gap in clk cycles after the stream drains.
REQ-005 SHALL have parameter CW, default 16, meaning cycle counter width (constraint: 2**CW > TRST and 2**CW > TBIT).
REQ-006 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port clear_n  input  1  synchronous clear, active-low.
REQ-009 SHALL have port in_data  input  24  pixel word, GRB order, bit 23 first.
REQ-010 SHALL have port in_valid  input  1  upstream word available.
REQ-011 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-012 SHALL have port led_out  output  1  single-wire NRZ serial line to LED chain.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, SHIFT and LATCH.
REQ-015 SHALL complete a transfer only when in_valid and in_ready are both high on a rising clk edge; in_data SHALL be captured into a 24-bit shift register on that edge.
REQ-016 SHALL drive in_ready combinationally high in IDLE, and in SHIFT only on the last cycle (cycle count = TBIT-1) of bit 0; in_ready SHALL be low in all other cycles, including all of LATCH.
REQ-017 SHALL transition from IDLE to SHIFT on a transfer; led_out SHALL go high on the cycle after the accepting edge (latency 1).
REQ-018 SHALL, in SHIFT, hold led_out high for T1H cycles when the current bit is 1 or T0H cycles when it is 0, then low for the remainder of TBIT cycles.
REQ-019 SHALL transmit bits MSB first (23 down to 0), with the bit index decrementing at each bit-period boundary.
REQ-020 SHALL, at the end of bit 0 with a transfer in the same cycle, load the new word and start its bit 23 immediately, with no gap (back-to-back words).
REQ-021 SHALL, at the end of bit 0 without a transfer, enter LATCH with led_out low for exactly TRST cycles, then return to IDLE.
REQ-022 SHALL ignore in_valid during LATCH; a pending word SHALL be accepted on the first IDLE cycle.
REQ-023 SHALL, when clear_n is low at a clock edge, go to IDLE, drive led_out low, reset all counters, and discard the current word; clear_n SHALL take priority over a transfer.
REQ-024 SHALL count the cycle counter 0..TBIT-1 in SHIFT and 0..TRST-1 in LATCH, and SHALL never wrap within a state.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force state IDLE, led_out 0, busy 0, counters 0 and the shift register 0; in_ready SHALL then be 1.
REQ-026 SHALL abort a word in flight on reset mid-operation with no further pulse; after release, the next word SHALL restart at bit 23.

Structure
REQ-027 SHALL take the state encoding and the default timing constants (T0H/T1H/TBIT/TRST) from a shared package, ws2812_pkg.
REQ-028 SHALL have no sub-module; the upstream simple FIFO connects its read port directly to in_data/in_valid/in_ready.

Verification
REQ-029 SHALL cover a single word: 0x800000 with in_valid for one IDLE cycle -> bit 23 high for 16 cycles, bits 22..0 high for 8 cycles each, 600 cycles total, then 1000 low cycles, then busy 0.
REQ-030 SHALL cover back-to-back words: 0xFFFFFF then 0x000000 held valid -> second word accepted on cycle 599 of the first, 48 contiguous bit periods, no gap.
REQ-031 SHALL cover data during LATCH: in_valid asserted at LATCH cycle 10 -> in_ready 0 until IDLE, word accepted exactly TRST cycles after LATCH entry.
REQ-032 SHALL cover clear mid-word: clear_n low at bit 12 -> led_out 0 and state IDLE next cycle, no LATCH, and in_ready 1.
REQ-033 SHALL cover async reset mid-word: rst_n low for 3 cycles during a high phase -> led_out 0 immediately; the next word 0xA5A5A5 is transmitted correctly from bit 23.
